box_filter_kxk: RTL and testbench

- Parametrised successor of the 3x3 box averager in the user_logic image path.
- Accepts one K-pixel vertical column per transfer and keeps a sliding KxK window.
- Emits one filtered pixel per full window, in one of three runtime modes: rounded mean, centre passthrough or window maximum.
- Uses a true valid/ready handshake with full backpressure and line-start priming.

---
 rtl/box_filter_kxk_if.sv | 25 ++
 rtl/box_filter_kxk.sv | 123 ++++++++++++
 tb/tb_box_filter_kxk.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/box_filter_kxk_if.sv
// Column-in / pixel-out stream bundle for box_filter_kxk.
// i_* fields are driven towards the filter, o_* fields come back from it.
interface box_filter_kxk_if #(
  parameter int PIX_W = 8,
  parameter int K     = 3
);
  logic [K*PIX_W-1:0] i_pixel_col;
  logic               i_sol;
  logic [1:0]         i_mode;
  logic               i_pixel_valid;
  logic               o_pixel_ack;
  logic [PIX_W-1:0]   o_pixel;
  logic               o_pixel_valid;
  logic               i_pixel_ack;

  modport master (
    output i_pixel_col, i_sol, i_mode, i_pixel_valid, i_pixel_ack,
    input  o_pixel_ack, o_pixel, o_pixel_valid
  );

  modport slave (
    input  i_pixel_col, i_sol, i_mode, i_pixel_valid, i_pixel_ack,
    output o_pixel_ack, o_pixel, o_pixel_valid
  );
endinterface

// File: rtl/box_filter_kxk.sv
// Sliding KxK window filter: rounded mean, centre passthrough or max.
// Four-stage pipeline (window, column reduce, total, output) with global stall.
module box_col_reduce #(
  parameter int PIX_W = 8,
  parameter int K     = 3,
  parameter int SUM_W = 12
) (
  input  logic [K-1:0][PIX_W-1:0] col,
  output logic [SUM_W-1:0]        sum,
  output logic [PIX_W-1:0]        peak
);
  always_comb begin
    sum  = '0;
    peak = '0;
    for (int r = 0; r < K; r++) begin
      sum = sum + SUM_W'(col[r]);
      if (col[r] > peak) peak = col[r];
    end
  end
endmodule

module box_filter_kxk #(
  parameter  int PIX_W = 8,
  parameter  int K     = 3,
  localparam int SUM_W = PIX_W + $clog2(K*K)
) (
  input logic         i_clk,
  input logic         i_rst_n,
  box_filter_kxk_if.slave bus
);
  localparam int KK     = K * K;
  localparam int CTR    = (K - 1) / 2;
  localparam int CNT_W  = $clog2(K + 1);
  localparam int STAGES = 3;

  logic en, in_xfer;
  logic [STAGES:0]        vld_pipe;   // [0] window stage, [STAGES] output register
  logic [STAGES-1:0][1:0] mode_pipe;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  // win[c][r]: column 0 is the newest, row 0 is the top row
  logic [K-1:0][K-1:0][PIX_W-1:0] win;

  logic [K-1:0][SUM_W-1:0] col_sum, col_sum_q;
  logic [K-1:0][PIX_W-1:0] col_max, col_max_q;
  logic [PIX_W-1:0]        ctr2_q, ctr3_q, max3_q, pix_q;
  logic [SUM_W-1:0]        tot, tot_q, rnd;
  logic [PIX_W-1:0]        peak;

  assign en                = ~vld_pipe[STAGES] | bus.i_pixel_ack;
  assign in_xfer           = bus.i_pixel_valid & en;
  assign bus.o_pixel_ack   = en;
  assign bus.o_pixel_valid = vld_pipe[STAGES];
  assign bus.o_pixel       = pix_q;

  always_comb begin
    cnt_nxt = cnt;
    if (bus.i_sol)                cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_W'(K))    cnt_nxt = cnt + 1'b1;
  end

  // Window, prime counter and token bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win       <= '0;
      cnt       <= '0;
      vld_pipe  <= '0;
      mode_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_xfer && (cnt_nxt == CNT_W'(K))};
      mode_pipe <= {mode_pipe[STAGES-2:0], in_xfer ? bus.i_mode : mode_pipe[0]};
      if (in_xfer) begin
        cnt    <= cnt_nxt;
        win[0] <= bus.i_pixel_col;
        for (int c = 1; c < K; c++) win[c] <= bus.i_sol ? '0 : win[c-1];
      end
    end
  end

  for (genvar c = 0; c < K; c++) begin : g_col
    box_col_reduce #(.PIX_W(PIX_W), .K(K), .SUM_W(SUM_W)) u_red (
      .col  (win[c]),
      .sum  (col_sum[c]),
      .peak (col_max[c])
    );
  end

  always_comb begin
    tot  = '0;
    peak = '0;
    for (int c = 0; c < K; c++) begin
      tot = tot + col_sum_q[c];
      if (col_max_q[c] > peak) peak = col_max_q[c];
    end
  end

  // Round half up; the quotient never exceeds the largest pixel value
  assign rnd = tot_q + SUM_W'(KK / 2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_sum_q <= '0;
      col_max_q <= '0;
      ctr2_q    <= '0;
      tot_q     <= '0;
      max3_q    <= '0;
      ctr3_q    <= '0;
      pix_q     <= '0;
    end else if (en) begin
      col_sum_q <= col_sum;
      col_max_q <= col_max;
      ctr2_q    <= win[CTR][CTR];
      tot_q     <= tot;
      max3_q    <= peak;
      ctr3_q    <= ctr2_q;
      case (mode_pipe[STAGES-1])
        2'd1:    pix_q <= ctr3_q;
        2'd2:    pix_q <= max3_q;
        default: pix_q <= PIX_W'(rnd / SUM_W'(KK));
      endcase
    end
  end
endmodule

// File: tb/tb_box_filter_kxk.sv
// Directed bench for box_filter_kxk (K=3, PIX_W=8): vector table plus
// hand-written mode-switch, backpressure, mid-line sol and reset sequences.
module tb_box_filter_kxk;
  localparam int PIX_W = 8;
  localparam int K     = 3;
  localparam int CW    = K * PIX_W;
  localparam int NV    = 12;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  box_filter_kxk_if #(.PIX_W(PIX_W), .K(K)) bus ();
  box_filter_kxk #(.PIX_W(PIX_W), .K(K)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  typedef struct {
    logic [CW-1:0] c0, c1, c2;
    logic [1:0]    mode;
    int            exp;
  } vec_t;

  vec_t tv[NV];
  int checks = 0, failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int q_val[$];
  int q_cyc[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk)
    if (bus.o_pixel_valid && bus.i_pixel_ack) begin
      q_val.push_back(int'(bus.o_pixel));
      q_cyc.push_back(cyc);
    end

  function automatic logic [CW-1:0] col(input int a, input int b, input int c);
    return {PIX_W'(c), PIX_W'(b), PIX_W'(a)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send_col(input logic [CW-1:0] c, input logic s, input logic [1:0] m);
    bit done;
    done = 1'b0;
    bus.i_pixel_col   = c;
    bus.i_sol         = s;
    bus.i_mode        = m;
    bus.i_pixel_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge i_clk);
      done = bus.o_pixel_ack;
      @(posedge i_clk); #1;
    end
    chk("send_accept", int'(done), 1);
    last_acc = cyc;
    bus.i_pixel_valid = 1'b0;
    bus.i_sol         = 1'b0;
  endtask

  task automatic clear_q();
    q_val.delete();
    q_cyc.delete();
  endtask

  initial begin
    int acc;
    int exp_bp[8];
    int exp_ms[3];
    int held;

    tv[0]  = '{col(9,9,9),       col(9,9,9),       col(9,9,9),       2'd0, 9};
    tv[1]  = '{col(13,0,0),      col(0,0,0),       col(0,0,0),       2'd0, 1};
    tv[2]  = '{col(14,0,0),      col(0,0,0),       col(0,0,0),       2'd0, 2};
    tv[3]  = '{col(255,255,255), col(255,255,255), col(255,255,255), 2'd0, 255};
    tv[4]  = '{col(6,7,8),       col(3,4,5),       col(0,1,2),       2'd2, 8};
    tv[5]  = '{col(6,7,8),       col(3,4,5),       col(0,1,2),       2'd1, 4};
    tv[6]  = '{col(10,20,30),    col(40,50,60),    col(70,80,90),    2'd3, 50};
    tv[7]  = '{col(1,2,3),       col(4,77,6),      col(7,8,9),       2'd1, 77};
    tv[8]  = '{col(1,2,3),       col(4,77,6),      col(7,8,9),       2'd0, 13};
    tv[9]  = '{col(1,2,3),       col(4,77,6),      col(7,8,200),     2'd2, 200};
    tv[10] = '{col(0,22,0),      col(0,0,0),       col(0,0,0),       2'd0, 2};
    tv[11] = '{col(0,0,0),       col(0,0,0),       col(0,0,23),      2'd0, 3};
    exp_bp = '{5, 10, 17, 26, 37, 50, 65, 82};
    exp_ms = '{20, 45, 45};

    bus.i_pixel_col   = '0;
    bus.i_sol         = 1'b0;
    bus.i_mode        = 2'd0;
    bus.i_pixel_valid = 1'b0;
    bus.i_pixel_ack   = 1'b1;

    #2;
    chk("rst_valid", int'(bus.o_pixel_valid), 0);
    chk("rst_ack",   int'(bus.o_pixel_ack), 1);
    chk("rst_pixel", int'(bus.o_pixel), 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_valid", int'(bus.o_pixel_valid), 0);
    chk("post_rst_ack",   int'(bus.o_pixel_ack), 1);

    // Table: one full window per vector, sol on the first column
    for (int i = 0; i < NV; i++) begin
      clear_q();
      send_col(tv[i].c0, 1'b1, tv[i].mode);
      send_col(tv[i].c1, 1'b0, tv[i].mode);
      send_col(tv[i].c2, 1'b0, tv[i].mode);
      acc = last_acc;
      idle(6);
      chk($sformatf("vec%0d_count", i), q_val.size(), 1);
      if (q_val.size() > 0) begin
        chk($sformatf("vec%0d_pixel", i), q_val[0], tv[i].exp);
        chk($sformatf("vec%0d_latency", i), q_cyc[0] - acc, 3);
      end
    end

    // Mode changes between consecutive columns
    clear_q();
    send_col(col(10,10,10), 1'b1, 2'd0);
    send_col(col(20,20,20), 1'b0, 2'd0);
    send_col(col(30,30,30), 1'b0, 2'd0);
    send_col(col(40,45,40), 1'b0, 2'd2);
    send_col(col(60,90,60), 1'b0, 2'd1);
    idle(6);
    chk("modesw_count", q_val.size(), 3);
    for (int i = 0; i < 3 && i < q_val.size(); i++)
      chk($sformatf("modesw_pix%0d", i), q_val[i], exp_ms[i]);

    // Backpressure: downstream stalls 5 cycles mid-stream
    clear_q();
    fork
      begin
        for (int j = 1; j <= 10; j++) send_col(col(j*j, j*j, j*j), j == 1, 2'd0);
      end
      begin
        for (int n = 0; n < 100 && !bus.o_pixel_valid; n++) @(negedge i_clk);
        chk("bp_saw_valid", int'(bus.o_pixel_valid), 1);
        @(posedge i_clk);
        @(posedge i_clk); #1;
        bus.i_pixel_ack = 1'b0;
        @(negedge i_clk);
        held = int'(bus.o_pixel);
        chk("bp_ack_low", int'(bus.o_pixel_ack), 0);
        chk("bp_valid",   int'(bus.o_pixel_valid), 1);
        repeat (4) begin
          @(negedge i_clk);
          chk("bp_ack_low", int'(bus.o_pixel_ack), 0);
          chk("bp_valid",   int'(bus.o_pixel_valid), 1);
          chk("bp_hold",    int'(bus.o_pixel), held);
        end
        @(posedge i_clk); #1;
        bus.i_pixel_ack = 1'b1;
        #1 chk("bp_ack_return", int'(bus.o_pixel_ack), 1);
      end
    join
    idle(8);
    chk("bp_count", q_val.size(), 8);
    for (int i = 0; i < 8 && i < q_val.size(); i++)
      chk($sformatf("bp_pix%0d", i), q_val[i], exp_bp[i]);

    // Mid-line sol; an unqualified sol between columns 5 and 6 is ignored
    clear_q();
    for (int j = 1; j <= 5; j++) send_col(col(200,200,200), j == 1, 2'd0);
    bus.i_sol = 1'b1;
    idle(1);
    bus.i_sol = 1'b0;
    send_col(col(200,200,200), 1'b0, 2'd0);
    send_col(col(9,9,9),       1'b1, 2'd0);
    send_col(col(18,18,18),    1'b0, 2'd0);
    idle(5);
    chk("sol_no_early", q_val.size(), 4);
    send_col(col(27,27,27), 1'b0, 2'd0);
    acc = last_acc;
    idle(5);
    chk("sol_count", q_val.size(), 5);
    if (q_val.size() == 5) begin
      chk("sol_old_pix", q_val[3], 200);
      chk("sol_new_pix", q_val[4], 18);
      chk("sol_latency", q_cyc[4] - acc, 3);
    end

    // Reset with three tokens in flight
    clear_q();
    for (int j = 1; j <= 5; j++) send_col(col(9,9,9), j == 1, 2'd0);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.o_pixel_valid), 0);
    chk("mid_rst_ack",   int'(bus.o_pixel_ack), 1);
    @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_rst_pixel", int'(bus.o_pixel), 0);
    send_col(col(9,9,9), 1'b0, 2'd0);
    send_col(col(9,9,9), 1'b0, 2'd0);
    idle(6);
    chk("rst_no_stale", q_val.size(), 0);
    send_col(col(9,9,9), 1'b0, 2'd0);
    acc = last_acc;
    idle(5);
    chk("rst_first_count", q_val.size(), 1);
    if (q_val.size() > 0) begin
      chk("rst_first_pix", q_val[0], 9);
      chk("rst_first_latency", q_cyc[0] - acc, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
